// File: rtl/vga_timing_driver.sv
// ---------------------------------------------------------------------------
// vga_timing_driver
//
// Generates VGA raster timing from a single pixel clock and pulls colour
// from an external image generator.
//
// A pair of free-running counters (h_cnt, v_cnt) walks the raster.  While the
// counters point at a visible pixel the block publishes 1-based coordinates
// (x, y) to the image generator, which answers with a 3-bit colour exactly
// COLOR_LATENCY clocks later.  Sync and blank are delayed by COLOR_LATENCY+1
// register stages so they line up with that colour once it is registered.
//
// Ports
//   CLOCK_25     in   pixel clock (only clock of the block)
//   RESET_N      in   asynchronous, active-low reset
//   color[2:0]   in   pixel colour from the image generator {r, g, b}
//   x[11:0]      out  1-based column of the current pixel, 0 when blanked
//   y[11:0]      out  1-based row of the current pixel, 0 when blanked
//   VGA_HS       out  horizontal sync, asserted level = SYNC_POL
//   VGA_VS       out  vertical sync, asserted level = SYNC_POL
//   VGA_R/G/B    out  registered colour, forced to 0 while blanked
//   VGA_BLANK_N  out  high while the driven pixel is visible
//   frame_start  out  one-clock pulse when the counters sit at (0,0)
//
// Interface behaviour
//   There is no valid/ready handshake: x/y are valid on every clock in which
//   they are non-zero, and color is sampled unconditionally COLOR_LATENCY
//   clocks after the coordinate it belongs to.  A colour presented for a
//   blanked coordinate is discarded.
//
// Parameters
//   COLOR_LATENCY is intended for 0..3.  Counters are 10 bits wide, so
//   H_TOTAL and V_TOTAL must not exceed 1024.
// ---------------------------------------------------------------------------
module vga_timing_driver #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit SYNC_POL      = 1'b0,
  parameter int COLOR_LATENCY = 0
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        VGA_BLANK_N,
  output logic        frame_start
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int CW      = 10;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int STAGES  = COLOR_LATENCY + 1;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // -------------------------------------------------------------------------
  // Raster counters
  //
  // `running` is low in reset and for the first clock after release.  That
  // first clock only raises `running` while the counters stay at (0,0), so
  // the origin (x=1, y=1, frame_start=1) is presented on the first rising
  // edge after RESET_N goes high, and the counters advance from there.
  // -------------------------------------------------------------------------
  logic          running;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      running <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (!running) begin
      running <= 1'b1;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        // v_cnt moves only on the line wrap; at the frame corner both
        // counters return to 0 on the same clock.
        if (v_wrap) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + CW'(1);
        end
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Undelayed raster decode (registered counters only, so glitch-free)
  // -------------------------------------------------------------------------
  logic active_raw;
  logic hs_raw;
  logic vs_raw;

  assign active_raw = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs_raw     = running && (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_raw     = running && (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  assign x           = active_raw ? (12'(h_cnt) + 12'd1) : 12'd0;
  assign y           = active_raw ? (12'(v_cnt) + 12'd1) : 12'd0;
  assign frame_start = running && (h_cnt == '0) && (v_cnt == '0);

  // -------------------------------------------------------------------------
  // Alignment pipeline
  //
  // Each *_tap vector is {pipe, raw}; tap[i] is the value i clocks after the
  // counters, so tap[STAGES] is the output stage.  Building the shift from
  // the tap avoids a zero-width slice when STAGES is 1.
  // -------------------------------------------------------------------------
  logic [STAGES-1:0] hs_pipe;
  logic [STAGES-1:0] vs_pipe;
  logic [STAGES-1:0] act_pipe;
  logic [STAGES:0]   hs_tap;
  logic [STAGES:0]   vs_tap;
  logic [STAGES:0]   act_tap;
  logic              rgb_en;
  logic [2:0]        rgb_q;

  assign hs_tap  = {hs_pipe, hs_raw};
  assign vs_tap  = {vs_pipe, vs_raw};
  assign act_tap = {act_pipe, active_raw};

  // The colour for a coordinate arrives COLOR_LATENCY clocks after it, i.e.
  // in the same clock as the active flag that feeds the last stage.
  // Registering it against that flag keeps RGB aligned with sync and blank.
  assign rgb_en = act_tap[STAGES-1];

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      act_pipe <= '0;
      rgb_q    <= 3'b000;
    end else begin
      hs_pipe  <= hs_tap[STAGES-1:0];
      vs_pipe  <= vs_tap[STAGES-1:0];
      act_pipe <= act_tap[STAGES-1:0];
      rgb_q    <= rgb_en ? color : 3'b000;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  //
  // The pipeline stores "asserted" rather than a pin level, so clearing it
  // in reset drives the deasserted level for either sync polarity.
  // -------------------------------------------------------------------------
  assign VGA_HS      = hs_pipe[STAGES-1] ? SYNC_POL : !SYNC_POL;
  assign VGA_VS      = vs_pipe[STAGES-1] ? SYNC_POL : !SYNC_POL;
  assign VGA_BLANK_N = act_pipe[STAGES-1];

  // rgb_q is already zero for blanked pixels; the extra gate keeps the pins
  // dark even if a colour is registered for a pixel that ends up blanked.
  assign VGA_R = rgb_q[2] & VGA_BLANK_N;
  assign VGA_G = rgb_q[1] & VGA_BLANK_N;
  assign VGA_B = rgb_q[0] & VGA_BLANK_N;

endmodule
